// File: rtl/alu_issue_sched.sv
// alu_issue_sched: ALU reservation station. It holds dispatched ops until both operands arrive, then issues one op per cycle.
// Define AGE_ORDER_ISSUE_EN to issue the oldest ready entry instead of the lowest-index ready entry.
module alu_issue_sched #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [5:0]       in_op,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic [TAG_W-1:0] in_rd_rename,
  input  logic             in_q1_busy,
  input  logic [TAG_W-1:0] in_q1,
  input  logic [31:0]      in_v1,
  input  logic             in_q2_busy,
  input  logic [TAG_W-1:0] in_q2,
  input  logic [31:0]      in_v2,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [31:0]      lsb_value,
  output logic             full,
  output logic             alu_enable,
  output logic [5:0]       alu_op,
  output logic [31:0]      alu_pc,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [TAG_W-1:0] alu_rd_rename
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] ent_valid;
  logic [RS_SIZE-1:0] ent_q1_busy;
  logic [RS_SIZE-1:0] ent_q2_busy;
  logic [5:0]         ent_op  [RS_SIZE];
  logic [31:0]        ent_pc  [RS_SIZE];
  logic [31:0]        ent_imm [RS_SIZE];
  logic [TAG_W-1:0]   ent_rd  [RS_SIZE];
  logic [TAG_W-1:0]   ent_q1  [RS_SIZE];
  logic [TAG_W-1:0]   ent_q2  [RS_SIZE];
  logic [31:0]        ent_v1  [RS_SIZE];
  logic [31:0]        ent_v2  [RS_SIZE];

  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_SIZE-1:0] q1_cdb_hit;
  logic [RS_SIZE-1:0] q1_lsb_hit;
  logic [RS_SIZE-1:0] q2_cdb_hit;
  logic [RS_SIZE-1:0] q2_lsb_hit;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               issue_fire;
  logic               dispatch_fire;
  logic               d_q1_busy;
  logic               d_q2_busy;
  logic [31:0]        d_v1;
  logic [31:0]        d_v2;

  // READY means both operands captured; selection only ever sees pre-edge state.
  assign ready_vec     = ent_valid & ~ent_q1_busy & ~ent_q2_busy;
  assign full          = &ent_valid;
  assign issue_fire    = |ready_vec;
  assign dispatch_fire = in_valid && !full;

  always_comb begin
    q1_cdb_hit = '0;
    q1_lsb_hit = '0;
    q2_cdb_hit = '0;
    q2_lsb_hit = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      q1_cdb_hit[i] = ent_valid[i] && ent_q1_busy[i] && cdb_valid && (ent_q1[i] == cdb_tag);
      q1_lsb_hit[i] = ent_valid[i] && ent_q1_busy[i] && lsb_valid && (ent_q1[i] == lsb_tag);
      q2_cdb_hit[i] = ent_valid[i] && ent_q2_busy[i] && cdb_valid && (ent_q2[i] == cdb_tag);
      q2_lsb_hit[i] = ent_valid[i] && ent_q2_busy[i] && lsb_valid && (ent_q2[i] == lsb_tag);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent_valid[i]) free_idx = IDX_W'(i);
    end
  end

  // Operands still busy at dispatch may be satisfied by a broadcast in the same cycle.
  always_comb begin
    d_q1_busy = in_q1_busy;
    d_v1      = in_v1;
    d_q2_busy = in_q2_busy;
    d_v2      = in_v2;
    if (in_q1_busy) begin
      if (cdb_valid && (cdb_tag == in_q1)) begin
        d_q1_busy = 1'b0;
        d_v1      = cdb_value;
      end else if (lsb_valid && (lsb_tag == in_q1)) begin
        d_q1_busy = 1'b0;
        d_v1      = lsb_value;
      end
    end
    if (in_q2_busy) begin
      if (cdb_valid && (cdb_tag == in_q2)) begin
        d_q2_busy = 1'b0;
        d_v2      = cdb_value;
      end else if (lsb_valid && (lsb_tag == in_q2)) begin
        d_q2_busy = 1'b0;
        d_v2      = lsb_value;
      end
    end
  end

`ifdef AGE_ORDER_ISSUE_EN
  // Age rank = number of older occupied entries; rank 0 is the oldest.
  logic [IDX_W-1:0] ent_age [RS_SIZE];
  logic [IDX_W-1:0] sel_age;
  logic             sel_hit;
  logic [CNT_W-1:0] valid_cnt;
  logic [IDX_W-1:0] new_age;

  always_comb begin
    sel_idx = '0;
    sel_age = '1;
    sel_hit = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready_vec[i] && (!sel_hit || (ent_age[i] < sel_age))) begin
        sel_idx = IDX_W'(i);
        sel_age = ent_age[i];
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_cnt = valid_cnt + CNT_W'(ent_valid[i]);
    end
    new_age = IDX_W'(valid_cnt - CNT_W'(issue_fire));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent_age[i] <= '0;
    end else if (rdy && !clr) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_valid[i] && issue_fire && (ent_age[i] > sel_age)) ent_age[i] <= ent_age[i] - 1'b1;
      end
      if (dispatch_fire) ent_age[free_idx] <= new_age;
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready_vec[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  // Entry occupancy and operand-busy flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid   <= '0;
      ent_q1_busy <= '0;
      ent_q2_busy <= '0;
    end else if (rdy) begin
      if (clr) begin
        ent_valid <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (q1_cdb_hit[i] || q1_lsb_hit[i]) ent_q1_busy[i] <= 1'b0;
          if (q2_cdb_hit[i] || q2_lsb_hit[i]) ent_q2_busy[i] <= 1'b0;
        end
        if (issue_fire) ent_valid[sel_idx] <= 1'b0;
        if (dispatch_fire) begin
          ent_valid[free_idx]   <= 1'b1;
          ent_q1_busy[free_idx] <= d_q1_busy;
          ent_q2_busy[free_idx] <= d_q2_busy;
        end
      end
    end
  end

  // Payload storage needs no reset; it is only read while the entry is valid.
  always_ff @(posedge clk) begin
    if (rdy && !clr) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (q1_cdb_hit[i])      ent_v1[i] <= cdb_value;
        else if (q1_lsb_hit[i]) ent_v1[i] <= lsb_value;
        if (q2_cdb_hit[i])      ent_v2[i] <= cdb_value;
        else if (q2_lsb_hit[i]) ent_v2[i] <= lsb_value;
      end
      if (dispatch_fire) begin
        ent_op[free_idx]  <= in_op;
        ent_pc[free_idx]  <= in_pc;
        ent_imm[free_idx] <= in_imm;
        ent_rd[free_idx]  <= in_rd_rename;
        ent_q1[free_idx]  <= in_q1;
        ent_q2[free_idx]  <= in_q2;
        ent_v1[free_idx]  <= d_v1;
        ent_v2[free_idx]  <= d_v2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_enable    <= 1'b0;
      alu_op        <= '0;
      alu_pc        <= '0;
      alu_imm       <= '0;
      alu_rs1       <= '0;
      alu_rs2       <= '0;
      alu_rd_rename <= '0;
    end else if (rdy) begin
      if (clr) begin
        alu_enable <= 1'b0;
      end else if (issue_fire) begin
        alu_enable    <= 1'b1;
        alu_op        <= ent_op[sel_idx];
        alu_pc        <= ent_pc[sel_idx];
        alu_imm       <= ent_imm[sel_idx];
        alu_rs1       <= ent_v1[sel_idx];
        alu_rs2       <= ent_v2[sel_idx];
        alu_rd_rename <= ent_rd[sel_idx];
      end else begin
        alu_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb_alu_issue_sched: directed-vector bench for alu_issue_sched with hand-computed expectations.
// Build with AGE_ORDER_ISSUE_EN defined to check oldest-first selection.
module tb_alu_issue_sched;

`ifdef AGE_ORDER_ISSUE_EN
  localparam bit AGE_MODE = 1'b1;
`else
  localparam bit AGE_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic        in_valid;
  logic [5:0]  in_op;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [3:0]  in_rd_rename;
  logic        in_q1_busy;
  logic [3:0]  in_q1;
  logic [31:0] in_v1;
  logic        in_q2_busy;
  logic [3:0]  in_q2;
  logic [31:0] in_v2;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        lsb_valid;
  logic [3:0]  lsb_tag;
  logic [31:0] lsb_value;
  logic        full;
  logic        alu_enable;
  logic [5:0]  alu_op;
  logic [31:0] alu_pc;
  logic [31:0] alu_imm;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [3:0]  alu_rd_rename;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_issue_sched #(.RS_SIZE(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .in_valid(in_valid), .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm), .in_rd_rename(in_rd_rename),
    .in_q1_busy(in_q1_busy), .in_q1(in_q1), .in_v1(in_v1),
    .in_q2_busy(in_q2_busy), .in_q2(in_q2), .in_v2(in_v2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value),
    .full(full), .alu_enable(alu_enable), .alu_op(alu_op), .alu_pc(alu_pc), .alu_imm(alu_imm),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd_rename(alu_rd_rename)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    lsb_valid = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic drive_dispatch(input logic [3:0] rd, input logic q1b, input logic [3:0] q1, input logic [31:0] v1,
                                input logic q2b, input logic [3:0] q2, input logic [31:0] v2);
    in_valid     = 1'b1;
    in_op        = 6'h01;
    in_pc        = 32'h1000 + 32'(rd);
    in_imm       = 32'h20 + 32'(rd);
    in_rd_rename = rd;
    in_q1_busy   = q1b;
    in_q1        = q1;
    in_v1        = v1;
    in_q2_busy   = q2b;
    in_q2        = q2;
    in_v2        = v2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rdy = 1'b1;
    idle();
    drive_dispatch(4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    in_valid = 1'b0;
    #2;
    tests_run++;
    if (alu_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_enable: got %0b want 0", alu_enable); end
    tests_run++;
    if (alu_rs1 !== 32'h0 || alu_rs2 !== 32'h0 || alu_pc !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_data: rs1=%h rs2=%h pc=%h want 0", alu_rs1, alu_rs2, alu_pc);
    end
    tests_run++;
    if (full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full: got %0b want 0", full); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_issue();
    drive_dispatch(4'd2, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
    tick();
    idle();
    tests_run++;
    if (alu_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_latency: enable=%0b want 0", alu_enable); end
    tick();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7) begin
      tests_failed++; $display("[TB] FAIL basic_issue: en=%0b rs1=%0d rs2=%0d want 1/5/7", alu_enable, alu_rs1, alu_rs2);
    end
    tests_run++;
    if (alu_op !== 6'h01 || alu_rd_rename !== 4'd2 || alu_pc !== 32'h1002 || alu_imm !== 32'h22) begin
      tests_failed++; $display("[TB] FAIL basic_fields: op=%h rd=%0d pc=%h imm=%h want 01/2/1002/22", alu_op, alu_rd_rename, alu_pc, alu_imm);
    end
    tick();
    tests_run++;
    if (alu_enable !== 1'b0 || alu_rs1 !== 32'd5) begin
      tests_failed++; $display("[TB] FAIL basic_one_cycle: en=%0b rs1=%0d want 0/5", alu_enable, alu_rs1);
    end
  endtask

  task automatic test_cdb_wakeup();
    drive_dispatch(4'd6, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd2);
    tick();
    idle();
    tick();
    tests_run++;
    if (alu_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL cdb_wait: enable=%0b want 0", alu_enable); end
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'h10;
    tick();
    idle();
    tests_run++;
    if (alu_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL cdb_no_same_cycle: enable=%0b want 0", alu_enable); end
    tick();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs1 !== 32'h10 || alu_rs2 !== 32'd2 || alu_rd_rename !== 4'd6) begin
      tests_failed++; $display("[TB] FAIL cdb_issue: en=%0b rs1=%h rs2=%h rd=%0d want 1/10/2/6", alu_enable, alu_rs1, alu_rs2, alu_rd_rename);
    end
    tick();
    tests_run++;
    if (alu_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL cdb_drain: enable=%0b want 0", alu_enable); end
  endtask

  task automatic test_lsb_bypass();
    drive_dispatch(4'd7, 1'b0, 4'd0, 32'd1, 1'b1, 4'd9, 32'd0);
    lsb_valid = 1'b1; lsb_tag = 4'd9; lsb_value = 32'hAB;
    tick();
    idle();
    tick();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs2 !== 32'hAB || alu_rs1 !== 32'd1) begin
      tests_failed++; $display("[TB] FAIL lsb_bypass: en=%0b rs1=%h rs2=%h want 1/1/ab", alu_enable, alu_rs1, alu_rs2);
    end
    tick();
    tests_run++;
    if (alu_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL lsb_drain: enable=%0b want 0", alu_enable); end
  endtask

  task automatic test_rdy_freeze();
    drive_dispatch(4'd1, 1'b0, 4'd0, 32'h31, 1'b0, 4'd0, 32'h32);
    tick();
    idle();
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++;
      if (alu_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL rdy_hold_idle: cycle %0d enable=%0b want 0", k, alu_enable); end
    end
    rdy = 1'b1;
    tick();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs1 !== 32'h31) begin
      tests_failed++; $display("[TB] FAIL rdy_resume: en=%0b rs1=%h want 1/31", alu_enable, alu_rs1);
    end
    rdy = 1'b0;
    tick();
    tests_run++;
    if (alu_enable !== 1'b1) begin tests_failed++; $display("[TB] FAIL rdy_hold_enable: enable=%0b want 1", alu_enable); end
    rdy = 1'b1;
    tick();
    tests_run++;
    if (alu_enable !== 1'b0 || alu_rs1 !== 32'h31) begin
      tests_failed++; $display("[TB] FAIL rdy_after: en=%0b rs1=%h want 0/31", alu_enable, alu_rs1);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 8; k++) begin
      drive_dispatch(4'(k), 1'b1, 4'(k), 32'd0, 1'b0, 4'd0, 32'h2);
      tick();
    end
    idle();
    tests_run++;
    if (full !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_set: got %0b want 1", full); end
    drive_dispatch(4'd15, 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    idle();
    tests_run++;
    if (full !== 1'b1 || alu_enable !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL full_ignore: full=%0b en=%0b want 1/0", full, alu_enable);
    end
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'h55;
    tick();
    idle();
    drive_dispatch(4'd14, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'h78);
    tick();
    idle();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs1 !== 32'h55 || alu_rd_rename !== 4'd0) begin
      tests_failed++; $display("[TB] FAIL full_wake_issue: en=%0b rs1=%h rd=%0d want 1/55/0", alu_enable, alu_rs1, alu_rd_rename);
    end
    tests_run++;
    if (full !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_freed: got %0b want 0", full); end
    drive_dispatch(4'd13, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'h9A);
    tick();
    idle();
    tests_run++;
    if (full !== 1'b1 || alu_enable !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL full_refill: full=%0b en=%0b want 1/0", full, alu_enable);
    end
    tick();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs1 !== 32'h99 || alu_rd_rename !== 4'd13) begin
      tests_failed++; $display("[TB] FAIL full_late_dispatch: en=%0b rs1=%h rd=%0d want 1/99/13", alu_enable, alu_rs1, alu_rd_rename);
    end
    clr = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_age_order();
    for (int k = 0; k < 6; k++) begin
      drive_dispatch(4'(k), 1'b1, 4'(k), 32'd0, 1'b0, 4'd0, 32'd0);
      tick();
    end
    idle();
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h22;
    tick();
    idle();
    tick();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs1 !== 32'h22) begin
      tests_failed++; $display("[TB] FAIL age_first_slot2: en=%0b rs1=%h want 1/22", alu_enable, alu_rs1);
    end
    drive_dispatch(4'd10, 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    idle();
    cdb_valid = 1'b1; cdb_tag = 4'd5;  cdb_value = 32'h55;
    lsb_valid = 1'b1; lsb_tag = 4'd10; lsb_value = 32'hAA;
    tick();
    idle();
    tests_run++;
    if (alu_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL age_wake_wait: enable=%0b want 0", alu_enable); end
    tick();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs1 !== (AGE_MODE ? 32'h55 : 32'hAA) || alu_rd_rename !== (AGE_MODE ? 4'd5 : 4'd10)) begin
      tests_failed++; $display("[TB] FAIL age_pick1: en=%0b rs1=%h rd=%0d age_mode=%0b", alu_enable, alu_rs1, alu_rd_rename, AGE_MODE);
    end
    tick();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs1 !== (AGE_MODE ? 32'hAA : 32'h55) || alu_rd_rename !== (AGE_MODE ? 4'd10 : 4'd5)) begin
      tests_failed++; $display("[TB] FAIL age_pick2: en=%0b rs1=%h rd=%0d age_mode=%0b", alu_enable, alu_rs1, alu_rd_rename, AGE_MODE);
    end
    clr = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_clr();
    for (int k = 0; k < 4; k++) begin
      drive_dispatch(4'(k + 4), 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'(k));
      tick();
    end
    idle();
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'h70;
    tick();
    idle();
    clr = 1'b1;
    drive_dispatch(4'd12, 1'b0, 4'd0, 32'hC1, 1'b0, 4'd0, 32'hC2);
    tick();
    idle();
    tests_run++;
    if (alu_enable !== 1'b0 || full !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL clr_flush: en=%0b full=%0b want 0/0", alu_enable, full);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (alu_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_no_issue: cycle %0d enable=%0b want 0", k, alu_enable); end
    end
  endtask

  task automatic test_reset_mid();
    drive_dispatch(4'd3, 1'b0, 4'd0, 32'h41, 1'b0, 4'd0, 32'h42);
    tick();
    drive_dispatch(4'd8, 1'b1, 4'd4, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    idle();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs1 !== 32'h41) begin
      tests_failed++; $display("[TB] FAIL rstmid_pre: en=%0b rs1=%h want 1/41", alu_enable, alu_rs1);
    end
    rst = 1'b0;
    #2;
    tests_run++;
    if (alu_enable !== 1'b0 || alu_rs1 !== 32'h0 || alu_rs2 !== 32'h0 || alu_rd_rename !== 4'd0 || full !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rstmid_async: en=%0b rs1=%h rs2=%h rd=%0d full=%0b want all 0", alu_enable, alu_rs1, alu_rs2, alu_rd_rename, full);
    end
    #2;
    rst = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_value = 32'h44;
    tick();
    idle();
    tick();
    tests_run++;
    if (alu_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_discard: enable=%0b want 0", alu_enable); end
    drive_dispatch(4'd9, 1'b0, 4'd0, 32'h61, 1'b0, 4'd0, 32'h62);
    tick();
    idle();
    tick();
    tests_run++;
    if (alu_enable !== 1'b1 || alu_rs1 !== 32'h61) begin
      tests_failed++; $display("[TB] FAIL rstmid_recover: en=%0b rs1=%h want 1/61", alu_enable, alu_rs1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_lsb_bypass();
    test_rdy_freeze();
    test_full();
    test_age_order();
    test_clr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
